expmul_pipe: RTL

- Parametrised, fully backpressured successor to the single-register exp-multiply stage.
- Computes v_out[i] = exp(a - b) * v_in[i] over a VEC_LEN-lane vector using the shift-only Log2Exp approximation. b is the running row maximum.
- Sits between the score/max unit and the P·V accumulator in the attention datapath.
- Three-stage valid/ready pipeline with per-stage bubble collapsing, a sideband tag, and an underflow flag.

---
 rtl/expmul_pipe_pkg.sv | 17 +
 rtl/expmul_pipe_log2exp_shift.sv | 43 ++++
 rtl/expmul_pipe.sv | 132 +++++++++++++
 3 files changed

// File: rtl/expmul_pipe_pkg.sv
// Shared attention-datapath types and constants.
// Includes the shift type and the fixed-point log2(e) constants used by the exp-multiply path.
package expmul_pipe_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int VEC_LEN_DEF = 16;
  localparam int SHIFT_W_DEF = 5;

  // log2(e) ~= 23/16, i.e. 1 + 1/2 - 1/16
  localparam int LOG2E_NUM  = 23;
  localparam int LOG2E_FRAC = 4;

  typedef logic signed [DATA_W_DEF-1:0]          INT_T;
  typedef logic [VEC_LEN_DEF*DATA_W_DEF-1:0]     STAR_VECTOR_T;
  typedef logic [SHIFT_W_DEF-1:0]                EXP_SHIFT_T;

endpackage

// File: rtl/expmul_pipe_log2exp_shift.sv
// Maps a max-relative exponent d = a - b onto the right-shift amount that approximates exp(d).
// The block is purely combinational and handles the clamp, the rounding and the saturation.
module log2exp_shift
  import expmul_pipe_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int SHIFT_W = 5
) (
  input  logic signed [DATA_W:0]  i_d,
  output logic [SHIFT_W-1:0]      o_s
);

  localparam int T_W = DATA_W + 8;
  localparam logic signed [T_W-1:0] NUM  = T_W'(LOG2E_NUM);
  localparam logic signed [T_W-1:0] HALF = T_W'(1 << (LOG2E_FRAC - 1));
  localparam logic signed [T_W-1:0] SAT  = T_W'((1 << SHIFT_W) - 1);

  logic signed [DATA_W:0] w_dc;
  logic signed [T_W-1:0]  w_dx;
  logic signed [T_W-1:0]  w_t;
  logic signed [T_W-1:0]  w_q;
  logic signed [T_W-1:0]  w_s;

  // clamp positive d, scale by log2(e), round to nearest with ties toward +inf, saturate
  always_comb begin
    w_dc = '0;
    if (i_d > 0) begin
      w_dc = '0;
    end else begin
      w_dc = i_d;
    end
    w_dx = {{(T_W-DATA_W-1){w_dc[DATA_W]}}, w_dc};
    w_t  = w_dx * NUM;
    w_q  = (w_t + HALF) >>> LOG2E_FRAC;
    w_s  = -w_q;
    if (w_s > SAT) begin
      o_s = '1;
    end else begin
      o_s = w_s[SHIFT_W-1:0];
    end
  end

endmodule

// File: rtl/expmul_pipe.sv
// Three-stage valid/ready pipeline that computes v_out[i] = exp(a - b) * v_in[i] with shift-only scaling.
// Each stage collapses bubbles independently, so up to three transactions are held while downstream stalls.
module expmul_pipe
  import expmul_pipe_pkg::*;
#(
  parameter int VEC_LEN = 16,
  parameter int DATA_W  = 8,
  parameter int TAG_W   = 4,
  parameter int SHIFT_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vld_in,
  output logic                       rdy_out,
  input  logic [DATA_W-1:0]          a_in,
  input  logic [DATA_W-1:0]          b_in,
  input  logic [VEC_LEN*DATA_W-1:0]  v_in,
  input  logic [TAG_W-1:0]           tag_in,
  output logic                       vld_out,
  input  logic                       rdy_in,
  output logic [VEC_LEN*DATA_W-1:0]  v_out,
  output logic [TAG_W-1:0]           tag_out,
  output logic                       uflow_out
);

  logic                       r_s1_vld;
  logic [DATA_W-1:0]          r_s1_a;
  logic [DATA_W-1:0]          r_s1_b;
  logic [VEC_LEN*DATA_W-1:0]  r_s1_v;
  logic [TAG_W-1:0]           r_s1_tag;

  logic                       r_s2_vld;
  logic [SHIFT_W-1:0]         r_s2_s;
  logic [VEC_LEN*DATA_W-1:0]  r_s2_v;
  logic [TAG_W-1:0]           r_s2_tag;

  logic                       r_s3_vld;
  logic [VEC_LEN*DATA_W-1:0]  r_s3_v;
  logic [TAG_W-1:0]           r_s3_tag;
  logic                       r_s3_uflow;

  logic                       w_adv1;
  logic                       w_adv2;
  logic                       w_adv3;
  logic signed [DATA_W:0]     w_d;
  logic [SHIFT_W-1:0]         w_s;
  logic                       w_uflow;
  logic [VEC_LEN*DATA_W-1:0]  w_scaled;

  // a stage moves when it is empty or the stage after it moves; nothing depends on vld_in
  always_comb begin
    w_adv3 = !r_s3_vld || rdy_in;
    w_adv2 = !r_s2_vld || w_adv3;
    w_adv1 = !r_s1_vld || w_adv2;
  end

  assign rdy_out   = w_adv1;
  assign vld_out   = r_s3_vld;
  assign v_out     = r_s3_v;
  assign tag_out   = r_s3_tag;
  assign uflow_out = r_s3_uflow;

  // one extra bit so the full a - b range is representable
  assign w_d = {r_s1_a[DATA_W-1], r_s1_a} - {r_s1_b[DATA_W-1], r_s1_b};

  log2exp_shift #(
    .DATA_W  (DATA_W),
    .SHIFT_W (SHIFT_W)
  ) u_log2exp_shift (
    .i_d (w_d),
    .o_s (w_s)
  );

  // per-lane arithmetic shift; shifts of DATA_W or more flush every lane to zero
  always_comb begin
    w_uflow  = (r_s2_s >= SHIFT_W'(DATA_W));
    w_scaled = '0;
    for (int i = 0; i < VEC_LEN; i++) begin
      if (w_uflow) begin
        w_scaled[i*DATA_W +: DATA_W] = '0;
      end else begin
        w_scaled[i*DATA_W +: DATA_W] = $signed(r_s2_v[i*DATA_W +: DATA_W]) >>> r_s2_s;
      end
    end
  end

  // stage registers; data only loads with a valid beat, valids follow the advance chain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld   <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_v     <= '0;
      r_s1_tag   <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_s     <= '0;
      r_s2_v     <= '0;
      r_s2_tag   <= '0;
      r_s3_vld   <= 1'b0;
      r_s3_v     <= '0;
      r_s3_tag   <= '0;
      r_s3_uflow <= 1'b0;
    end else begin
      if (w_adv1) begin
        r_s1_vld <= vld_in;
        if (vld_in) begin
          r_s1_a   <= a_in;
          r_s1_b   <= b_in;
          r_s1_v   <= v_in;
          r_s1_tag <= tag_in;
        end
      end
      if (w_adv2) begin
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_s2_s   <= w_s;
          r_s2_v   <= r_s1_v;
          r_s2_tag <= r_s1_tag;
        end
      end
      if (w_adv3) begin
        r_s3_vld <= r_s2_vld;
        if (r_s2_vld) begin
          r_s3_v     <= w_scaled;
          r_s3_tag   <= r_s2_tag;
          r_s3_uflow <= w_uflow;
        end
      end
    end
  end

endmodule
